fetch_queue: RTL and testbench

- Consumer end of the PC path.
- Takes the current fetch address from the PC adder and issues one instruction-memory request at a time.
- Buffers returned {pc, instr} pairs in a small FIFO for decode.
- Pulses pc_advance back to the PC each time a fetch completes. Branch redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: issues one instruction-memory request at a time from the
// current PC and buffers returned {pc, instr} pairs in a small FIFO for
// decode. A redirect flushes the FIFO and drops any response still in flight.
module fetch_queue #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_advance,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [INSTR_W-1:0] dec_instr,
    input  logic               dec_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    logic               discard;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic               space;
    logic               push;
    logic               pop;

    // A push only ever comes from a request issued with room available, so
    // it can never overflow; a flush suppresses both push and pop.
    assign imem_req   = (state == S_WAIT);
    assign space      = (count < CNT_W'(DEPTH));
    assign push       = imem_req & imem_ack & ~discard & ~flush;
    assign dec_valid  = (count != '0);
    assign pop        = dec_valid & dec_ready & ~flush;
    assign pc_advance = push;
    assign dec_pc     = pc_mem[rd_ptr];
    assign dec_instr  = instr_mem[rd_ptr];

    // Request FSM: capture the PC on issue and hold it until the ack; a flush
    // mid-request marks the response to be dropped when it arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            discard   <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (space && !flush && !discard) begin
                        imem_addr <= pc_addr;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        discard <= 1'b0;
                        state   <= S_IDLE;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO occupancy and pointers; a flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference of the fetch rules.
module tb_fetch_queue;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               rst;
    logic [ADDR_W-1:0]  pc_addr;
    logic               pc_advance;
    logic               flush;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_valid;
    logic [ADDR_W-1:0]  dec_pc;
    logic [INSTR_W-1:0] dec_instr;
    logic               dec_ready;

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_addr   (pc_addr),
        .pc_advance(pc_advance),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .dec_valid (dec_valid),
        .dec_pc    (dec_pc),
        .dec_instr (dec_instr),
        .dec_ready (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    // Reference: FIFO contents, the outstanding request, and the PC adder.
    ent_t              q[$];
    bit                m_busy;
    bit                m_discard;
    logic [ADDR_W-1:0] m_addr;
    logic [ADDR_W-1:0] pc;

    int checks;
    int errors;
    int adv_cnt;
    int adv0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] rd_for(input logic [ADDR_W-1:0] a);
        return 32'h2008_0001 + 32'(a >> 2);
    endfunction

    // One clock cycle: drive inputs, check outputs, advance the reference.
    task automatic cyc(input bit r, input bit fl, input bit ack, input bit rdy,
                       input logic [INSTR_W-1:0] rd, input logic [ADDR_W-1:0] tgt);
        bit   e_adv;
        bit   do_issue;
        bit   do_pop;
        ent_t e;
        rst        = r;
        flush      = fl;
        imem_ack   = ack;
        dec_ready  = rdy;
        imem_rdata = rd;
        pc_addr    = pc;
        #1;
        e_adv = m_busy && ack && !m_discard && !fl;
        chk("imem_req", imem_req, m_busy);
        chk("imem_addr", imem_addr, m_addr);
        chk("pc_advance", pc_advance, e_adv);
        chk("dec_valid", dec_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("dec_pc", dec_pc, q[0].pc);
            chk("dec_instr", dec_instr, q[0].instr);
        end
        if (pc_advance === 1'b1) adv_cnt++;
        if (r) begin
            q.delete();
            m_busy    = 0;
            m_discard = 0;
            m_addr    = '0;
            pc        = '0;
        end else begin
            do_issue = !m_busy && (q.size() < DEPTH) && !fl;
            do_pop   = (q.size() != 0) && rdy && !fl;
            if (fl) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (e_adv) begin
                    e.pc    = m_addr;
                    e.instr = rd;
                    q.push_back(e);
                end
            end
            if (m_busy) begin
                if (ack) begin
                    m_busy    = 0;
                    m_discard = 0;
                end else if (fl) begin
                    m_discard = 1;
                end
            end else if (do_issue) begin
                m_busy = 1;
                m_addr = pc;
            end
            if (fl) pc = tgt;
            else if (e_adv) pc = pc + 64'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        adv_cnt    = 0;
        m_busy     = 0;
        m_discard  = 0;
        m_addr     = '0;
        pc         = '0;
        rst        = 1'b1;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        dec_ready  = 1'b0;
        imem_rdata = '0;
        pc_addr    = '0;
        repeat (2) @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", dec_valid, 0);

        // Reset while a request is outstanding
        cyc(0, 0, 0, 0, 0, 0);
        chk("issue_after_rst", imem_req, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_wait_req", imem_req, 0);
        chk("rst_wait_valid", dec_valid, 0);

        // Fill with decode stalled
        adv_cnt = 0;
        for (int i = 0; i < 12; i++) cyc(0, 0, m_busy, 0, rd_for(m_addr), 0);
        chk("fill_adv", adv_cnt, 4);
        chk("fill_req_idle", imem_req, 0);
        chk("fill_head_pc", dec_pc, 64'h0);
        chk("fill_head_instr", dec_instr, 32'h2008_0001);

        // Drain in order; a new request to 0x10 issues once space opens
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", dec_pc, 64'(4 * k));
            chk("drain_instr", dec_instr, 32'h2008_0001 + 32'(k));
            cyc(0, 0, 0, 1, 0, 0);
        end
        chk("drain_empty", dec_valid, 0);
        chk("pend_req", imem_req, 1);
        chk("pend_addr", imem_addr, 64'h10);

        // Flush two cycles before the ack of 0x10
        cyc(0, 1, 0, 0, 0, 64'h8400);
        chk("flush_empty", dec_valid, 0);
        chk("flush_hold_req", imem_req, 1);
        chk("flush_hold_addr", imem_addr, 64'h10);
        adv0 = adv_cnt;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'hdead_beef, 0);
        chk("discard_no_adv", adv_cnt, adv0);
        chk("discard_no_push", dec_valid, 0);
        chk("discard_idle", imem_req, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 64'h8400);

        // Flush with the ack in the same cycle
        cyc(0, 0, 1, 0, rd_for(m_addr), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("next_addr", imem_addr, 64'h8404);
        adv0 = adv_cnt;
        cyc(0, 1, 1, 0, 32'hbad0_0001, 64'h9000);
        chk("fa_no_adv", adv_cnt, adv0);
        chk("fa_idle", imem_req, 0);
        chk("fa_empty", dec_valid, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("fa_redir_req", imem_req, 1);
        chk("fa_redir_addr", imem_addr, 64'h9000);

        // Three entries queued, then push and pop together
        for (int i = 0; i < 20 && q.size() < 3; i++) cyc(0, 0, m_busy, 0, rd_for(m_addr), 0);
        for (int i = 0; i < 5 && !m_busy; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("pp_req", imem_req, 1);
        cyc(0, 0, 1, 1, rd_for(m_addr), 0);
        for (int k = 1; k <= 3; k++) begin
            chk("pp_head", dec_pc, 64'h9000 + 64'(4 * k));
            cyc(0, 0, 0, 1, 0, 0);
        end

        // Pointer wrap: refill with interleaved pops
        for (int i = 0; i < 24; i++) cyc(0, 0, m_busy, (i % 3) == 0, rd_for(m_addr), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                $urandom, {$urandom, $urandom} & ~64'h3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
